// File: rtl/tl_buf_pkg.sv
// Shared widths, field offsets and opcode constants for the TileLink A/D buffer.
package tl_buf_pkg;

  localparam int unsigned A_WIDTH = 113;
  localparam int unsigned D_WIDTH = 71;

  localparam int unsigned A_DATA_OFF    = 0;
  localparam int unsigned A_MASK_OFF    = 64;
  localparam int unsigned A_ADDRESS_OFF = 72;
  localparam int unsigned A_SIZE_OFF    = 104;
  localparam int unsigned A_PARAM_OFF   = 107;
  localparam int unsigned A_OPCODE_OFF  = 110;

  localparam int unsigned D_DATA_OFF    = 0;
  localparam int unsigned D_DENIED_OFF  = 64;
  localparam int unsigned D_SIZE_OFF    = 65;
  localparam int unsigned D_OPCODE_OFF  = 68;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  function automatic logic [A_WIDTH-1:0] pack_a(input logic [2:0] opcode, input logic [2:0] param,
                                                input logic [2:0] size, input logic [31:0] address,
                                                input logic [7:0] mask, input logic [63:0] data);
    return {opcode, param, size, address, mask, data};
  endfunction

  function automatic logic [D_WIDTH-1:0] pack_d(input logic [2:0] opcode, input logic [2:0] size,
                                                input logic denied, input logic [63:0] data);
    return {opcode, size, denied, data};
  endfunction

endpackage

// File: rtl/tl_buf_fifo2.sv
// Two-entry registered FIFO with 1-bit wrapping pointers; no flow-through, and
// ready depends only on the stored count, never on the consumer's ready.
module tl_buf_fifo2
  import tl_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_bits_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_bits_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             enq_s, deq_s;

  // Both handshakes are masked during reset so a flush never produces a fire.
  assign in_ready_o  = (count_q != 2'd2) && !reset;
  assign out_valid_o = (count_q != 2'd0) && !reset;
  assign out_bits_o  = mem_q[rd_ptr_q];
  assign enq_s       = in_valid_i && in_ready_o;
  assign deq_s       = out_valid_o && out_ready_i;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      mem_q[wr_ptr_q] <= in_bits_i;
    end
  end

endmodule

// File: rtl/tl_a_d_buffer.sv
// TileLink A/D buffer with outstanding-request limiting on the A path.
// Macro TL_BUF_D_QUEUE_EN selects a 2-entry D FIFO; otherwise D is a passthrough.
module tl_a_d_buffer
  import tl_buf_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_a_valid,
  output logic               in_a_ready,
  input  logic [A_WIDTH-1:0] in_a_bits,
  output logic               out_a_valid,
  input  logic               out_a_ready,
  output logic [A_WIDTH-1:0] out_a_bits,
  input  logic               in_d_valid,
  output logic               in_d_ready,
  input  logic [D_WIDTH-1:0] in_d_bits,
  output logic               out_d_valid,
  input  logic               out_d_ready,
  output logic [D_WIDTH-1:0] out_d_bits,
  output logic [2:0]         inflight
);

  localparam logic [2:0] MAX_INFLIGHT_C = 3'(MAX_INFLIGHT);

  logic [2:0] inflight_q, inflight_d;
  logic       credit_ok_s;
  logic       a_fifo_valid_s;
  logic       a_fire_s;
  logic       d_fire_s;

  assign credit_ok_s = inflight_q < MAX_INFLIGHT_C;
  assign out_a_valid = a_fifo_valid_s && credit_ok_s;
  assign a_fire_s    = out_a_valid && out_a_ready;
  assign inflight    = inflight_q;

  tl_buf_fifo2 #(.WIDTH(A_WIDTH)) u_a_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (in_a_valid),
    .in_ready_o  (in_a_ready),
    .in_bits_i   (in_a_bits),
    .out_valid_o (a_fifo_valid_s),
    .out_ready_i (out_a_ready && credit_ok_s),
    .out_bits_o  (out_a_bits)
  );

`ifdef TL_BUF_D_QUEUE_EN
  tl_buf_fifo2 #(.WIDTH(D_WIDTH)) u_d_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (in_d_valid),
    .in_ready_o  (in_d_ready),
    .in_bits_i   (in_d_bits),
    .out_valid_o (out_d_valid),
    .out_ready_i (out_d_ready),
    .out_bits_o  (out_d_bits)
  );
  assign d_fire_s = out_d_valid && out_d_ready;
`else
  assign out_d_valid = in_d_valid;
  assign out_d_bits  = in_d_bits;
  assign in_d_ready  = out_d_ready && !reset;
  assign d_fire_s    = in_d_valid && in_d_ready;
`endif

  // Outstanding count: simultaneous issue and response cancel; decrement saturates at zero.
  always_comb begin
    inflight_d = inflight_q;
    if (a_fire_s && !d_fire_s) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!a_fire_s && d_fire_s && (inflight_q != 3'd0)) begin
      inflight_d = inflight_q - 3'd1;
    end else begin
      inflight_d = inflight_q;
    end
  end

  // Outstanding-count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 3'd0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_tl_a_d_buffer.sv
// Directed bench for tl_a_d_buffer; follows the D-path build selected by TL_BUF_D_QUEUE_EN.
module tb_tl_a_d_buffer;
  import tl_buf_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic [A_WIDTH-1:0] in_a_bits, out_a_bits;
  logic               in_d_valid, in_d_ready, out_d_valid, out_d_ready;
  logic [D_WIDTH-1:0] in_d_bits, out_d_bits;
  logic [2:0]         inflight;

  int tests = 0;
  int fails = 0;

  logic [A_WIDTH-1:0] g0, g1, g2, p0, p1, g1000;
  logic [D_WIDTH-1:0] ack0, ack1, ack2, ack_dead, ackd;

  tl_a_d_buffer #(.MAX_INFLIGHT(2)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_bits(in_a_bits),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_bits(in_d_bits),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_bits(out_d_bits),
    .inflight(inflight)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    g0       = {3'd4, 3'd0, 3'd3, 32'h0000_0100, 8'hFF, 64'h0};
    g1       = {3'd4, 3'd0, 3'd3, 32'h0000_0108, 8'hFF, 64'h0};
    g2       = {3'd4, 3'd0, 3'd2, 32'h0000_0110, 8'h0F, 64'h0};
    p0       = {3'd0, 3'd0, 3'd3, 32'h0000_2000, 8'hFF, 64'h1111_2222_3333_4444};
    p1       = {3'd0, 3'd0, 3'd3, 32'h0000_2008, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD};
    g1000    = {3'd4, 3'd0, 3'd3, 32'h0000_1000, 8'hFF, 64'h0};
    ack0     = {3'd1, 3'd3, 1'b0, 64'h0123_4567_89AB_CDEF};
    ack1     = {3'd1, 3'd3, 1'b0, 64'hFEDC_BA98_7654_3210};
    ack2     = {3'd0, 3'd3, 1'b1, 64'h0};
    ack_dead = {3'd0, 3'd2, 1'b0, 64'h0000_0000_DEAD_BEEF};
    ackd     = {3'd1, 3'd3, 1'b0, 64'h5A5A_A5A5_0F0F_F0F0};

    reset = 1'b1; in_a_valid = 1'b0; in_a_bits = '0; out_a_ready = 1'b0;
    in_d_valid = 1'b0; in_d_bits = '0; out_d_ready = 1'b1;
    tick(); tick();
    check("rst_in_a_ready", in_a_ready, 0);
    check("rst_in_d_ready", in_d_ready, 0);
    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_out_d_valid", out_d_valid, 0);
    check("rst_inflight", inflight, 0);
    reset = 1'b0; #1;
    check("post_rst_in_a_ready", in_a_ready, 1);
    check("post_rst_in_d_ready", in_d_ready, 1);
    check("post_rst_out_a_valid", out_a_valid, 0);

    // Three Gets back to back, no responses: two forwarded, third held.
    out_a_ready = 1'b1; in_a_valid = 1'b1; in_a_bits = g0;
    tick();
    check("get0_valid", out_a_valid, 1);
    check("get0_bits", out_a_bits, g0);
    in_a_bits = g1;
    tick();
    check("get1_bits", out_a_bits, g1);
    check("get1_inflight", inflight, 1);
    in_a_bits = g2;
    tick();
    in_a_valid = 1'b0; #1;
    check("get2_inflight", inflight, 2);
    check("get2_held_valid", out_a_valid, 0);
    check("get2_in_a_ready", in_a_ready, 1);
    tick();
    check("hold_inflight", inflight, 2);
    check("hold_out_a_valid", out_a_valid, 0);

`ifdef TL_BUF_D_QUEUE_EN
    in_d_valid = 1'b1; in_d_bits = ack0; #1;
    check("dq_no_flow_through", out_d_valid, 0);
    check("dq_in_d_ready", in_d_ready, 1);
    tick();
    check("dq_ack0_valid", out_d_valid, 1);
    check("dq_ack0_bits", out_d_bits, ack0);
    in_d_bits = ack1;
    tick();
    in_d_valid = 1'b0; #1;
    check("dq_dec_inflight", inflight, 1);
    check("dq_g2_released", out_a_bits, g2);
    check("dq_ack1_bits", out_d_bits, ack1);
    tick();
    check("both_fire_inflight", inflight, 1);
    check("both_fire_a_empty", out_a_valid, 0);
    check("dq_empty", out_d_valid, 0);
    in_d_valid = 1'b1; in_d_bits = ack2;
    tick();
    in_d_valid = 1'b0;
    tick();
    check("drain_inflight", inflight, 0);
    // Spurious response at zero outstanding.
    in_d_valid = 1'b1; in_d_bits = ack_dead;
    tick();
    in_d_valid = 1'b0; #1;
    check("spur_valid", out_d_valid, 1);
    check("spur_bits", out_d_bits, ack_dead);
    tick();
    check("spur_inflight", inflight, 0);
`else
    in_d_valid = 1'b1; in_d_bits = ack0; #1;
    check("pt_ack0_valid", out_d_valid, 1);
    check("pt_ack0_bits", out_d_bits, ack0);
    check("pt_in_d_ready", in_d_ready, 1);
    tick();
    check("pt_dec_inflight", inflight, 1);
    check("pt_g2_valid", out_a_valid, 1);
    check("pt_g2_bits", out_a_bits, g2);
    in_d_bits = ack1;
    tick();
    check("both_fire_inflight", inflight, 1);
    check("both_fire_a_empty", out_a_valid, 0);
    in_d_bits = ack2;
    tick();
    check("drain_inflight", inflight, 0);
    // Spurious response at zero outstanding.
    in_d_bits = ack_dead; #1;
    check("spur_valid", out_d_valid, 1);
    check("spur_bits", out_d_bits, ack_dead);
    tick();
    in_d_valid = 1'b0; #1;
    check("spur_inflight", inflight, 0);
`endif

    // Fill the A FIFO with downstream stalled, then release it.
    out_a_ready = 1'b0; in_a_valid = 1'b1; in_a_bits = p0;
    tick();
    in_a_bits = p1;
    tick();
    in_a_valid = 1'b0; #1;
    check("full_in_a_ready", in_a_ready, 0);
    check("full_out_a_valid", out_a_valid, 1);
    check("full_head_bits", out_a_bits, p0);
    out_a_ready = 1'b1; #1;
    check("full_fire_in_a_ready", in_a_ready, 0);
    tick();
    out_a_ready = 1'b0; #1;
    check("after_deq_in_a_ready", in_a_ready, 1);
    check("after_deq_bits", out_a_bits, p1);
    check("after_deq_inflight", inflight, 1);
    out_a_ready = 1'b1;
    tick();
    check("p1_inflight", inflight, 2);
    check("p1_out_a_valid", out_a_valid, 0);

    // Fill both paths, then reset mid-operation.
    in_a_valid = 1'b1; in_a_bits = p0; in_d_valid = 1'b1; in_d_bits = ack0; out_d_ready = 1'b0;
    tick();
    in_a_bits = p1; in_d_bits = ack1;
    tick();
    in_a_valid = 1'b0; in_d_valid = 1'b0; #1;
    check("pre_rst_in_a_ready", in_a_ready, 0);
    check("pre_rst_inflight", inflight, 2);
`ifdef TL_BUF_D_QUEUE_EN
    check("pre_rst_in_d_ready", in_d_ready, 0);
`endif
    reset = 1'b1; out_d_ready = 1'b1; #1;
    check("mid_rst_out_a_valid", out_a_valid, 0);
    check("mid_rst_out_d_valid", out_d_valid, 0);
    check("mid_rst_in_a_ready", in_a_ready, 0);
    tick();
    check("rst2_inflight", inflight, 0);
    check("rst2_out_a_valid", out_a_valid, 0);
    reset = 1'b0; #1;
    check("rel_in_a_ready", in_a_ready, 1);
    check("rel_in_d_ready", in_d_ready, 1);
    check("rel_out_d_valid", out_d_valid, 0);
    in_a_valid = 1'b1; in_a_bits = g1000;
    tick();
    in_a_valid = 1'b0; #1;
    check("g1000_valid", out_a_valid, 1);
    check("g1000_bits", out_a_bits, pack_a(OP_GET, 3'd0, 3'd3, 32'h0000_1000, 8'hFF, 64'h0));
    check("g1000_inflight0", inflight, 0);
    tick();
    check("g1000_inflight1", inflight, 1);
    check("no_stale_a", out_a_valid, 0);

    // AccessAckData response with downstream ready toggled.
`ifdef TL_BUF_D_QUEUE_EN
    in_d_valid = 1'b1; in_d_bits = ackd; #1;
    check("ackd_no_flow_through", out_d_valid, 0);
    tick();
    in_d_valid = 1'b0; #1;
    check("ackd_valid", out_d_valid, 1);
    check("ackd_bits", out_d_bits, pack_d(OP_ACCESS_ACK_DATA, 3'd3, 1'b0, 64'h5A5A_A5A5_0F0F_F0F0));
    tick();
    check("ackd_inflight", inflight, 0);
    check("ackd_drained", out_d_valid, 0);
`else
    out_d_ready = 1'b0; in_d_valid = 1'b1; in_d_bits = ackd; #1;
    check("ackd_valid", out_d_valid, 1);
    check("ackd_bits", out_d_bits, pack_d(OP_ACCESS_ACK_DATA, 3'd3, 1'b0, 64'h5A5A_A5A5_0F0F_F0F0));
    check("ackd_ready_low", in_d_ready, 0);
    tick();
    check("ackd_no_fire_inflight", inflight, 1);
    out_d_ready = 1'b1; #1;
    check("ackd_ready_high", in_d_ready, 1);
    tick();
    in_d_valid = 1'b0; #1;
    check("ackd_inflight", inflight, 0);
    check("ackd_drained", out_d_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
